// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory access unit: access sizes, FSM states
// and the default memory word-index width.
package mem_pkg;

  localparam int ADDR_W_DEF = 10;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    MERGE,
    WR,
    RESP
  } state_e;

  // The unused size code 2'b11 behaves as a word access.
  function automatic size_e norm_size(input logic [1:0] sz);
    case (sz)
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_HALF: return off[0];
      SZ_WORD: return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Core request/response and data-memory signals of the access unit.
// resp_err exists only when MISALIGN_TRAP_EN is defined.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
`ifdef MISALIGN_TRAP_EN
  logic        resp_err;
`endif
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
`ifdef MISALIGN_TRAP_EN
    output resp_err,
`endif
    output req_ready, resp_valid, resp_rdata, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
`ifdef MISALIGN_TRAP_EN
    input  resp_err,
`endif
    input  req_ready, resp_valid, resp_rdata, mem_addr, mem_wdata, mem_we
  );

endinterface

// File: rtl/mem_lane_fmt.sv
// Combinational lane logic: little-endian load extraction with sign/zero
// extension, and sub-word lane merge for read-modify-write stores.
module mem_lane_fmt
  import mem_pkg::*;
(
  input  size_e       i_size,
  input  logic [1:0]  i_offset,
  input  logic        i_signed,
  input  logic [31:0] i_word,
  input  logic [15:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    w_byte   = i_word[{i_offset, 3'b000} +: 8];
    w_half   = i_offset[1] ? i_word[31:16] : i_word[15:0];
    o_load   = i_word;
    o_merged = i_word;
    case (i_size)
      SZ_BYTE: begin
        o_load = {{24{i_signed & w_byte[7]}}, w_byte};
        o_merged[{i_offset, 3'b000} +: 8] = i_wdata[7:0];
      end
      SZ_HALF: begin
        o_load = {{16{i_signed & w_half[15]}}, w_half};
        if (i_offset[1]) o_merged[31:16] = i_wdata;
        else             o_merged[15:0]  = i_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory initiator: byte-addressed loads/stores onto a word-indexed,
// synchronous-read memory. Optional MISALIGN_TRAP_EN traps misaligned requests.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  mem_access_unit_if.slave   bus
);

  state_e            r_state, w_state_nxt;
  logic              r_we;
  logic              r_sext;
  size_e             r_size;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_resp_rdata;

  size_e       w_in_size;
  logic        w_accept;
  logic        w_trap;
  logic [31:0] w_load;
  logic [31:0] w_merged;
  logic        w_unused_addr_hi;

  assign w_in_size        = norm_size(bus.req_size);
  assign w_accept         = (r_state == IDLE) && bus.req_valid;
  assign w_unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

`ifdef MISALIGN_TRAP_EN
  assign w_trap = is_misaligned(w_in_size, bus.req_addr[1:0]);
`else
  assign w_trap = 1'b0;
`endif

  mem_lane_fmt u_lane_fmt (
    .i_size   (r_size),
    .i_offset (r_addr[1:0]),
    .i_signed (r_sext),
    .i_word   (bus.mem_rdata),
    .i_wdata  (r_wdata[15:0]),
    .o_load   (w_load),
    .o_merged (w_merged)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          if (w_trap)                               w_state_nxt = RESP;
          else if (bus.req_we && w_in_size == SZ_WORD) w_state_nxt = WR;
          else                                      w_state_nxt = RD;
        end
      end
      RD:              w_state_nxt = r_we ? MERGE : CAP;
      CAP, MERGE, WR:  w_state_nxt = RESP;
      RESP:            w_state_nxt = IDLE;
      default:         w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_we         <= 1'b0;
      r_sext       <= 1'b0;
      r_size       <= SZ_BYTE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_resp_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_we    <= bus.req_we;
        r_sext  <= bus.req_signed;
        r_size  <= w_in_size;
        r_addr  <= bus.req_addr[ADDR_W+1:0];
        r_wdata <= bus.req_wdata;
      end
      // Loads capture the formatted lane; stores and traps report zero.
      case (r_state)
        CAP:       r_resp_rdata <= w_load;
        MERGE, WR: r_resp_rdata <= '0;
        IDLE:      if (w_accept && w_trap) r_resp_rdata <= '0;
        default: ;
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic r_resp_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     r_resp_err <= 1'b0;
    else if (w_accept)           r_resp_err <= w_trap;
    else if (r_state == RESP)    r_resp_err <= 1'b0;
  end

  assign bus.resp_err = r_resp_err;
`endif

  // Memory controls decode straight from state so reset drops mem_we at once.
  assign bus.req_ready  = (r_state == IDLE);
  assign bus.resp_valid = (r_state == RESP);
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.mem_we     = (r_state == MERGE) || (r_state == WR);
  assign bus.mem_addr   = {{(32-ADDR_W){1'b0}}, r_addr[ADDR_W+1:2]};

  always_comb begin
    bus.mem_wdata = '0;
    case (r_state)
      MERGE:   bus.mem_wdata = w_merged;
      WR:      bus.mem_wdata = r_wdata;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a read-before-write memory model.
// Builds with or without MISALIGN_TRAP_EN.
module tb_mem_access_unit;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   we_cnt = 0;
  int   we_cyc = 0;
  int   last_acc = 0;
  logic [31:0] last_we_addr = '0;
  logic [31:0] mem [0:1023];

  exp_t q_exp[$];
  int   q_acc[$];

  mem_access_unit_if bus ();

  mem_access_unit #(.ADDR_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read, read-before-write data memory.
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr[9:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_we) begin
        we_cnt++;
        we_cyc       = cyc;
        last_we_addr = bus.mem_addr;
      end
      if (bus.resp_valid) begin
        if (q_exp.size() == 0) begin
          check("resp_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          int   a;
          e = q_exp.pop_front();
          a = q_acc.pop_front();
          check("resp_rdata", bus.resp_rdata, e.rd);
          check("resp_latency", 32'(cyc - a + 1), 32'(e.lat));
`ifdef MISALIGN_TRAP_EN
          check("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
`endif
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                       input bit track, input bit keep);
    int n = 0;
    bus.req_we     = we;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    last_acc = cyc;
    if (track) begin
      q_exp.push_back('{exp_rd, exp_err, exp_lat});
      q_acc.push_back(cyc);
    end
    if (!keep) bus.req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((q_exp.size() != 0 || !bus.req_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (q_exp.size() != 0) check("drain_timeout", 32'(q_exp.size()), 32'd0);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0x00000000 expected 0x00000001");
    $fatal(1, "bench timed out");
  end

  initial begin
    int w0;
    int acc0;
    int n;
    logic [31:0] word5_before;

    for (int i = 0; i < 1024; i++) mem[i] = 32'(i) * 32'h0101_0101;
    mem[5]         = 32'h8844_2211;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready",  {31'd0, bus.req_ready},  32'd1);
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_resp_rdata", bus.resp_rdata,          32'd0);
    check("rst_mem_we",     {31'd0, bus.mem_we},     32'd0);
    check("rst_mem_addr",   bus.mem_addr,            32'd0);
    check("rst_mem_wdata",  bus.mem_wdata,           32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Loads of word 5 in every size.
    w0 = we_cnt;
    issue(1'b0, 2'b10, 1'b0, 32'h14, 0, 32'h8844_2211, 1'b0, 3, 1, 0); drain();
    check("ld_word_no_we", 32'(we_cnt - w0), 32'd0);
    issue(1'b0, 2'b00, 1'b1, 32'h17, 0, 32'hFFFF_FF88, 1'b0, 3, 1, 0); drain();
    issue(1'b0, 2'b00, 1'b0, 32'h17, 0, 32'h0000_0088, 1'b0, 3, 1, 0); drain();
    issue(1'b0, 2'b01, 1'b1, 32'h16, 0, 32'hFFFF_8844, 1'b0, 3, 1, 0); drain();
    issue(1'b0, 2'b01, 1'b1, 32'h14, 0, 32'h0000_2211, 1'b0, 3, 1, 0); drain();
    issue(1'b0, 2'b00, 1'b1, 32'h15, 0, 32'h0000_0022, 1'b0, 3, 1, 0); drain();

    // Half store via read-modify-write.
    w0 = we_cnt;
    issue(1'b1, 2'b01, 1'b0, 32'h16, 32'h1234_BEEF, 32'h0, 1'b0, 3, 1, 0); drain();
    check("st_half_we_pulses", 32'(we_cnt - w0), 32'd1);
    check("st_half_mem5", mem[5], 32'hBEEF_2211);
    issue(1'b0, 2'b10, 1'b0, 32'h14, 0, 32'hBEEF_2211, 1'b0, 3, 1, 0); drain();

    // Word store: single write one cycle after accept.
    w0 = we_cnt;
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1, 0);
    acc0 = last_acc;
    drain();
    check("st_word_we_pulses", 32'(we_cnt - w0), 32'd1);
    check("st_word_we_cycle", 32'(we_cyc - acc0 + 1), 32'd1);
    check("st_word_mem_addr", last_we_addr, 32'd8);
    check("st_word_mem8", mem[8], 32'hDEAD_BEEF);

    // Back-to-back loads with req_valid held high.
    issue(1'b0, 2'b10, 1'b0, 32'h14, 0, 32'hBEEF_2211, 1'b0, 3, 1, 1);
    acc0 = last_acc;
    n = 0;
    while (!bus.req_ready && n < 10) begin
      n++;
      @(negedge clk);
    end
    check("b2b_ready_low_cycles", 32'(n), 32'd3);
    issue(1'b0, 2'b00, 1'b0, 32'h20, 0, 32'h0000_00EF, 1'b0, 3, 1, 0);
    check("b2b_second_accept", 32'(last_acc - acc0), 32'd4);
    drain();

    // Reset asserted during MERGE of a byte store.
    word5_before = mem[5];
    issue(1'b1, 2'b00, 1'b0, 32'h14, 32'h0000_005A, 32'h0, 1'b0, 3, 0, 0);
    @(negedge clk);
    #1;
    check("merge_we_high", {31'd0, bus.mem_we}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_we_async", {31'd0, bus.mem_we}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    check("rst_mem5_kept", mem[5], word5_before);
    check("rst_ready_back", {31'd0, bus.req_ready}, 32'd1);

    // Normal service after reset: byte merge, then wrap and size 11.
    issue(1'b1, 2'b00, 1'b0, 32'h14, 32'hFFFF_FFA5, 32'h0, 1'b0, 3, 1, 0); drain();
    check("st_byte_mem5", mem[5], 32'hBEEF_22A5);
    issue(1'b0, 2'b00, 1'b1, 32'h17, 0, 32'hFFFF_FFBE, 1'b0, 3, 1, 0); drain();
    issue(1'b0, 2'b10, 1'b0, 32'h1014, 0, 32'hBEEF_22A5, 1'b0, 3, 1, 0); drain();
    issue(1'b0, 2'b11, 1'b1, 32'h20, 0, 32'hDEAD_BEEF, 1'b0, 3, 1, 0); drain();

    // Misaligned requests.
    w0 = we_cnt;
`ifdef MISALIGN_TRAP_EN
    issue(1'b0, 2'b10, 1'b0, 32'h15, 0, 32'h0, 1'b1, 1, 1, 0); drain();
    issue(1'b0, 2'b01, 1'b1, 32'h17, 0, 32'h0, 1'b1, 1, 1, 0); drain();
    issue(1'b1, 2'b10, 1'b0, 32'h16, 32'h1111_1111, 32'h0, 1'b1, 1, 1, 0); drain();
    check("trap_no_we", 32'(we_cnt - w0), 32'd0);
    check("trap_mem5_kept", mem[5], 32'hBEEF_22A5);
`else
    issue(1'b0, 2'b10, 1'b0, 32'h15, 0, 32'hBEEF_22A5, 1'b0, 3, 1, 0); drain();
    issue(1'b0, 2'b01, 1'b1, 32'h17, 0, 32'hFFFF_BEEF, 1'b0, 3, 1, 0); drain();
    check("misalign_no_we", 32'(we_cnt - w0), 32'd0);
`endif
    issue(1'b0, 2'b10, 1'b0, 32'h14, 0, 32'hBEEF_22A5, 1'b0, 3, 1, 0); drain();

    check("scoreboard_empty", 32'(q_exp.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
